// File: rtl/l1_dcache_wb_pkg.sv
// rtl/l1_dcache_wb_pkg.sv - state encodings and word helpers shared by the write-back L1 data cache
package l1_dcache_wb_pkg;
  typedef logic [31:0] word_t;

  localparam logic [3:0] ST_INIT      = 4'd0;
  localparam logic [3:0] ST_IDLE      = 4'd1;
  localparam logic [3:0] ST_LOOKUP    = 4'd2;
  localparam logic [3:0] ST_WB_REQ    = 4'd3;
  localparam logic [3:0] ST_FILL_REQ  = 4'd4;
  localparam logic [3:0] ST_FILL_WAIT = 4'd5;
  localparam logic [3:0] ST_FLUSH_RD  = 4'd6;
  localparam logic [3:0] ST_FLUSH_CHK = 4'd7;
  localparam logic [3:0] ST_FLUSH_WB  = 4'd8;

  function automatic word_t merge_word(input word_t old_w, input word_t new_w, input logic [3:0] mask);
    word_t r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = mask[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    return r;
  endfunction
endpackage

// File: rtl/l1_dcache_wb_ram.sv
// rtl/l1_dcache_wb_ram.sv - byte-writable single-port register-file RAM holding one cache way
module l1_dcache_wb_ram #(
  parameter int COLS   = 16,
  parameter int ADDR_W = 3
) (
  input  logic                clk,
  input  logic [COLS-1:0]     i_be,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [8*COLS-1:0]   i_wdata,
  output logic [8*COLS-1:0]   o_rdata
);
  logic [8*COLS-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    for (int c = 0; c < COLS; c++) begin
      if (i_be[c]) r_mem[i_addr][8*c +: 8] <= i_wdata[8*c +: 8];
    end
  end

  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/l1_dcache_wb.sv
// rtl/l1_dcache_wb.sv - blocking write-back write-allocate set-associative L1 data cache
module l1_dcache_wb
  import l1_dcache_wb_pkg::*;
#(
  parameter int ADDR_BITS  = 30,
  parameter int SET_BITS   = 3,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        core_req_valid,
  output logic                                        core_req_ready,
  input  logic                                        core_req_we,
  input  logic [ADDR_BITS-1:0]                        core_req_addr,
  input  logic [3:0]                                  core_req_mask,
  input  logic [31:0]                                 core_req_data,
  output logic                                        core_resp_valid,
  output logic [31:0]                                 core_resp_data,
  input  logic                                        flush_req,
  output logic                                        flush_done,
  output logic                                        bus_req_valid,
  input  logic                                        bus_req_ready,
  output logic                                        bus_req_we,
  output logic [ADDR_BITS-$clog2(LINE_WORDS)-1:0]     bus_req_addr,
  output logic [32*LINE_WORDS-1:0]                    bus_req_data,
  input  logic                                        bus_resp_valid,
  output logic                                        bus_resp_ready,
  input  logic [32*LINE_WORDS-1:0]                    bus_resp_data
);
  localparam int SETS        = 2**SET_BITS;
  localparam int OFFSET_BITS = $clog2(LINE_WORDS);
  localparam int TAG_BITS    = ADDR_BITS - SET_BITS - OFFSET_BITS;
  localparam int LINE_BITS   = 32*LINE_WORDS;
  localparam int WAY_BITS    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int COLS        = 4*LINE_WORDS;

  logic [3:0]             r_state;
  logic [SET_BITS-1:0]    r_set;
  logic [WAY_BITS-1:0]    r_way;
  logic [TAG_BITS-1:0]    r_tag;
  logic [OFFSET_BITS-1:0] r_off;
  logic                   r_we;
  logic [3:0]             r_mask;
  word_t                  r_wdata;
  logic [WAY_BITS-1:0]    r_victim;
  logic [TAG_BITS-1:0]    r_vtag;
  logic [LINE_BITS-1:0]   r_vline;

  logic [WAYS-1:0]        r_valid [SETS];
  logic [WAYS-1:0]        r_dirty [SETS];
  logic [TAG_BITS-1:0]    r_tags  [SETS][WAYS];
  logic [WAY_BITS-1:0]    r_rr    [SETS];

  logic [LINE_BITS-1:0]   w_rdata [WAYS];
  logic [COLS-1:0]        w_be    [WAYS];
  logic [LINE_BITS-1:0]   w_wdata;
  logic [LINE_BITS-1:0]   w_fill_line;
  logic                   w_hit;
  logic [WAY_BITS-1:0]    w_hit_way;
  logic [WAY_BITS-1:0]    w_victim;
  logic                   w_fl_dirty, w_way_last, w_set_last, w_flush_adv;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    l1_dcache_wb_ram #(.COLS(COLS), .ADDR_W(SET_BITS)) u_ram (
      .clk(clk), .i_be(w_be[g]), .i_addr(r_set), .i_wdata(w_wdata), .o_rdata(w_rdata[g])
    );
  end

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_victim  = r_rr[r_set];
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[r_set][w] && r_tags[r_set][w] == r_tag) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_BITS'(w);
      end
    end
    // Walk downwards so the lowest-index invalid way wins over round-robin.
    for (int w = WAYS-1; w >= 0; w--) begin
      if (!r_valid[r_set][w]) w_victim = WAY_BITS'(w);
    end
    w_fill_line = bus_resp_data;
    w_fill_line[32*r_off +: 32] = merge_word(bus_resp_data[32*r_off +: 32], r_wdata, r_we ? r_mask : 4'b0);
  end

  assign w_fl_dirty  = r_valid[r_set][r_way] && r_dirty[r_set][r_way];
  assign w_way_last  = (r_way == WAY_BITS'(WAYS-1));
  assign w_set_last  = (r_set == {SET_BITS{1'b1}});
  assign w_flush_adv = !rst && ((r_state == ST_FLUSH_CHK && !w_fl_dirty) ||
                                (r_state == ST_FLUSH_WB && bus_req_ready));

  always_comb begin
    for (int w = 0; w < WAYS; w++) w_be[w] = '0;
    w_wdata = {LINE_WORDS{r_wdata}};
    if (!rst && r_state == ST_LOOKUP && w_hit && r_we) begin
      w_be[w_hit_way] = COLS'(r_mask) << (4*r_off);
    end else if (!rst && r_state == ST_FILL_WAIT && bus_resp_valid) begin
      w_be[r_victim] = '1;
      w_wdata        = w_fill_line;
    end
  end

  always_comb begin
    core_req_ready  = 1'b0;
    core_resp_valid = 1'b0;
    core_resp_data  = '0;
    bus_req_valid   = 1'b0;
    bus_req_we      = 1'b0;
    bus_req_addr    = '0;
    bus_req_data    = '0;
    bus_resp_ready  = 1'b0;
    flush_done      = w_flush_adv && w_way_last && w_set_last;
    if (!rst) begin
      case (r_state)
        ST_IDLE: core_req_ready = !flush_req;
        ST_LOOKUP: begin
          core_resp_valid = w_hit;
          if (w_hit && !r_we) core_resp_data = w_rdata[w_hit_way][32*r_off +: 32];
        end
        ST_WB_REQ: begin
          bus_req_valid = 1'b1;
          bus_req_we    = 1'b1;
          bus_req_addr  = {r_vtag, r_set};
          bus_req_data  = r_vline;
        end
        ST_FILL_REQ: begin
          bus_req_valid = 1'b1;
          bus_req_addr  = {r_tag, r_set};
        end
        ST_FILL_WAIT: begin
          bus_resp_ready  = 1'b1;
          core_resp_valid = bus_resp_valid;
          if (bus_resp_valid && !r_we) core_resp_data = w_fill_line[32*r_off +: 32];
        end
        ST_FLUSH_WB: begin
          bus_req_valid = 1'b1;
          bus_req_we    = 1'b1;
          bus_req_addr  = {r_tags[r_set][r_way], r_set};
          bus_req_data  = w_rdata[r_way];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_set   <= '0;
      r_way   <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_valid[r_set] <= '0;
          r_dirty[r_set] <= '0;
          r_rr[r_set]    <= '0;
          r_set          <= r_set + 1'b1;
          if (w_set_last) r_state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (flush_req) begin
            r_set   <= '0;
            r_state <= ST_FLUSH_RD;
          end else if (core_req_valid) begin
            r_tag   <= core_req_addr[ADDR_BITS-1 -: TAG_BITS];
            r_set   <= core_req_addr[OFFSET_BITS +: SET_BITS];
            r_off   <= core_req_addr[OFFSET_BITS-1:0];
            r_we    <= core_req_we;
            r_mask  <= core_req_mask;
            r_wdata <= core_req_data;
            r_state <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (w_hit) begin
            if (r_we) r_dirty[r_set][w_hit_way] <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_victim <= w_victim;
            r_vtag   <= r_tags[r_set][w_victim];
            r_vline  <= w_rdata[w_victim];
            r_state  <= (r_valid[r_set][w_victim] && r_dirty[r_set][w_victim]) ? ST_WB_REQ : ST_FILL_REQ;
          end
        end
        ST_WB_REQ:   if (bus_req_ready) r_state <= ST_FILL_REQ;
        ST_FILL_REQ: if (bus_req_ready) r_state <= ST_FILL_WAIT;
        ST_FILL_WAIT: begin
          if (bus_resp_valid) begin
            r_valid[r_set][r_victim] <= 1'b1;
            r_dirty[r_set][r_victim] <= r_we;
            r_tags[r_set][r_victim]  <= r_tag;
            r_rr[r_set]              <= w_way_last_victim(r_victim);
            r_state                  <= ST_IDLE;
          end
        end
        ST_FLUSH_RD: begin
          r_way   <= '0;
          r_state <= ST_FLUSH_CHK;
        end
        ST_FLUSH_CHK: if (w_fl_dirty) r_state <= ST_FLUSH_WB;
        ST_FLUSH_WB: ;
        default: r_state <= ST_INIT;
      endcase
      // Shared step of the flush walk, taken from either a clean check or a completed write-back.
      if (w_flush_adv) begin
        r_valid[r_set][r_way] <= 1'b0;
        r_dirty[r_set][r_way] <= 1'b0;
        if (w_way_last) begin
          r_way <= '0;
          if (w_set_last) r_state <= ST_IDLE;
          else begin
            r_set   <= r_set + 1'b1;
            r_state <= ST_FLUSH_RD;
          end
        end else begin
          r_way   <= r_way + 1'b1;
          r_state <= ST_FLUSH_CHK;
        end
      end
    end
  end

  function automatic logic [WAY_BITS-1:0] w_way_last_victim(input logic [WAY_BITS-1:0] v);
    return (v == WAY_BITS'(WAYS-1)) ? '0 : v + 1'b1;
  endfunction
endmodule

// File: tb/tb_l1_dcache_wb.sv
// tb/tb_l1_dcache_wb.sv - directed self-checking bench for l1_dcache_wb
module tb_l1_dcache_wb;
  logic         clk = 1'b0;
  logic         rst;
  logic         core_req_valid, core_req_ready, core_req_we;
  logic [29:0]  core_req_addr;
  logic [3:0]   core_req_mask;
  logic [31:0]  core_req_data;
  logic         core_resp_valid;
  logic [31:0]  core_resp_data;
  logic         flush_req, flush_done;
  logic         bus_req_valid, bus_req_ready, bus_req_we;
  logic [27:0]  bus_req_addr;
  logic [127:0] bus_req_data;
  logic         bus_resp_valid, bus_resp_ready;
  logic [127:0] bus_resp_data;

  localparam logic [127:0] LINE_A = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
  localparam logic [127:0] LINE_B = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
  localparam logic [127:0] LINE_C = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
  localparam logic [127:0] LINE_D = {32'hD3, 32'hD2, 32'hD1, 32'hD0};

  int total = 0;
  int bad   = 0;
  logic         bus_we_q[$];
  logic [27:0]  bus_addr_q[$];
  logic [127:0] bus_data_q[$];
  int unstable;
  int stall_cycles;

  l1_dcache_wb dut (
    .clk(clk), .rst(rst),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready), .core_req_we(core_req_we),
    .core_req_addr(core_req_addr), .core_req_mask(core_req_mask), .core_req_data(core_req_data),
    .core_resp_valid(core_resp_valid), .core_resp_data(core_resp_data),
    .flush_req(flush_req), .flush_done(flush_done),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_we(bus_req_we),
    .bus_req_addr(bus_req_addr), .bus_req_data(bus_req_data),
    .bus_resp_valid(bus_resp_valid), .bus_resp_ready(bus_resp_ready), .bus_resp_data(bus_resp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  // Issue one core request and act as a bus slave (with optional request stall) until the response.
  task automatic core_op(input logic we, input logic [29:0] addr, input logic [3:0] mask,
                         input logic [31:0] data, input logic [127:0] fill, input int stall,
                         output logic [31:0] rdata, output int lat);
    int guard;
    logic pending, snap, s_we;
    logic [27:0] s_addr;
    logic [127:0] s_data;
    bus_we_q.delete(); bus_addr_q.delete(); bus_data_q.delete();
    unstable = 0; stall_cycles = 0; rdata = 'x; lat = -1;
    pending = 1'b0; snap = 1'b0; s_we = 1'b0; s_addr = '0; s_data = '0;
    @(negedge clk);
    core_req_valid = 1'b1; core_req_we = we; core_req_addr = addr;
    core_req_mask = mask; core_req_data = data;
    #1;
    guard = 0;
    while (!core_req_ready && guard < 50) begin @(negedge clk); #1; guard++; end
    @(negedge clk);
    core_req_valid = 1'b0; core_req_we = 1'b0; core_req_mask = '0; core_req_data = '0;
    for (int c = 1; c < 200; c++) begin
      bus_req_ready  = (stall_cycles >= stall);
      bus_resp_valid = pending;
      bus_resp_data  = fill;
      #1;
      if (bus_req_valid && !bus_req_ready) begin
        if (!snap) begin
          snap = 1'b1; s_we = bus_req_we; s_addr = bus_req_addr; s_data = bus_req_data;
        end else if (bus_req_we !== s_we || bus_req_addr !== s_addr || bus_req_data !== s_data) begin
          unstable++;
        end
        stall_cycles++;
      end
      if (bus_req_valid && bus_req_ready) begin
        bus_we_q.push_back(bus_req_we);
        bus_addr_q.push_back(bus_req_addr);
        bus_data_q.push_back(bus_req_data);
        if (!bus_req_we) pending = 1'b1;
        snap = 1'b0;
      end
      if (core_resp_valid) begin rdata = core_resp_data; lat = c; break; end
      @(negedge clk);
    end
    @(negedge clk);
    bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++; if (core_req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", core_req_ready); end
    total++; if (core_resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp got=%b want=0", core_resp_valid); end
    total++; if (flush_done !== 1'b0) begin bad++; $display("FAIL rst_flush_done got=%b want=0", flush_done); end
    total++; if (bus_req_valid !== 1'b0) begin bad++; $display("FAIL rst_bus_req got=%b want=0", bus_req_valid); end
    total++; if (bus_resp_ready !== 1'b0) begin bad++; $display("FAIL rst_bus_resp_ready got=%b want=0", bus_resp_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n = 0;
    while (!core_req_ready && n < 30) begin n++; @(negedge clk); #1; end
    total++; if (n !== 8) begin bad++; $display("FAIL init_cycles got=%0d want=8", n); end
  endtask

  task automatic test_cold_load();
    logic [31:0] r; int lat;
    core_op(1'b0, 30'h10, 4'h0, 32'h0, LINE_A, 0, r, lat);
    total++; if (bus_addr_q.size() !== 1) begin bad++; $display("FAIL cold_bus_count got=%0d want=1", bus_addr_q.size()); end
    total++; if (bus_we_q.size() < 1 || bus_we_q[0] !== 1'b0 || bus_addr_q[0] !== 28'h4) begin
      bad++; $display("FAIL cold_bus_read got_n=%0d want=read@4", bus_addr_q.size()); end
    total++; if (r !== 32'hA0) begin bad++; $display("FAIL cold_data got=%h want=000000a0", r); end
    total++; if (lat !== 3) begin bad++; $display("FAIL cold_latency got=%0d want=3", lat); end
  endtask

  task automatic test_store_hit();
    logic [31:0] r; int lat;
    core_op(1'b1, 30'h10, 4'b0001, 32'h11223344, LINE_A, 0, r, lat);
    total++; if (bus_addr_q.size() !== 0) begin bad++; $display("FAIL st_bus_count got=%0d want=0", bus_addr_q.size()); end
    total++; if (lat !== 1 || r !== 32'h0) begin bad++; $display("FAIL st_resp got=%0d/%h want=1/00000000", lat, r); end
    core_op(1'b0, 30'h10, 4'h0, 32'h0, LINE_A, 0, r, lat);
    total++; if (bus_addr_q.size() !== 0) begin bad++; $display("FAIL ld_hit_bus_count got=%0d want=0", bus_addr_q.size()); end
    total++; if (r !== 32'h00000044) begin bad++; $display("FAIL ld_merged got=%h want=00000044", r); end
    total++; if (lat !== 1) begin bad++; $display("FAIL ld_hit_latency got=%0d want=1", lat); end
    core_op(1'b0, 30'h11, 4'h0, 32'h0, LINE_A, 0, r, lat);
    total++; if (r !== 32'hA1 || lat !== 1) begin bad++; $display("FAIL ld_word1 got=%h/%0d want=000000a1/1", r, lat); end
  endtask

  task automatic test_evict();
    logic [31:0] r; int lat;
    core_op(1'b0, 30'h30, 4'h0, 32'h0, LINE_B, 0, r, lat);
    total++; if (bus_addr_q.size() !== 1 || bus_we_q[0] !== 1'b0 || bus_addr_q[0] !== 28'hC || r !== 32'hB0) begin
      bad++; $display("FAIL fill_way1 got_n=%0d data=%h want=read@c/000000b0", bus_addr_q.size(), r); end
    core_op(1'b0, 30'h52, 4'h0, 32'h0, LINE_C, 0, r, lat);
    total++; if (bus_addr_q.size() !== 2) begin bad++; $display("FAIL evict_count got=%0d want=2", bus_addr_q.size()); end
    total++; if (bus_we_q.size() < 1 || bus_we_q[0] !== 1'b1 || bus_addr_q[0] !== 28'h4) begin
      bad++; $display("FAIL evict_wb_addr got_n=%0d want=write@4", bus_addr_q.size()); end
    total++; if (bus_data_q.size() < 1 || bus_data_q[0] !== {32'hA3, 32'hA2, 32'hA1, 32'h00000044}) begin
      bad++; $display("FAIL evict_wb_data got_n=%0d want=a3_a2_a1_44", bus_data_q.size()); end
    total++; if (bus_we_q.size() < 2 || bus_we_q[1] !== 1'b0 || bus_addr_q[1] !== 28'h14) begin
      bad++; $display("FAIL evict_fill_addr got_n=%0d want=read@14", bus_addr_q.size()); end
    total++; if (r !== 32'hC2) begin bad++; $display("FAIL evict_data got=%h want=000000c2", r); end
    core_op(1'b0, 30'h30, 4'h0, 32'h0, LINE_B, 0, r, lat);
    total++; if (bus_addr_q.size() !== 0 || r !== 32'hB0) begin
      bad++; $display("FAIL way1_kept got_n=%0d data=%h want=0/000000b0", bus_addr_q.size(), r); end
    core_op(1'b0, 30'h10, 4'h0, 32'h0, LINE_A, 0, r, lat);
    total++; if (bus_addr_q.size() !== 1 || bus_we_q[0] !== 1'b0 || r !== 32'hA0) begin
      bad++; $display("FAIL rr_evict_clean got_n=%0d data=%h want=1/000000a0", bus_addr_q.size(), r); end
    core_op(1'b0, 30'h50, 4'h0, 32'h0, LINE_C, 0, r, lat);
    total++; if (bus_addr_q.size() !== 0 || r !== 32'hC0) begin
      bad++; $display("FAIL rr_pointer got_n=%0d data=%h want=0/000000c0", bus_addr_q.size(), r); end
  endtask

  task automatic test_flush();
    logic [31:0] r; int lat; logic done;
    core_op(1'b1, 30'h51, 4'hF, 32'hDEADBEEF, LINE_C, 0, r, lat);
    bus_we_q.delete(); bus_addr_q.delete(); bus_data_q.delete();
    done = 1'b0;
    @(negedge clk);
    flush_req = 1'b1; bus_req_ready = 1'b1;
    for (int c = 0; c < 300; c++) begin
      #1;
      if (bus_req_valid && bus_req_ready) begin
        bus_we_q.push_back(bus_req_we); bus_addr_q.push_back(bus_req_addr); bus_data_q.push_back(bus_req_data);
      end
      if (flush_done) begin done = 1'b1; flush_req = 1'b0; break; end
      @(negedge clk);
    end
    flush_req = 1'b0;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL flush_done got=%b want=1", done); end
    total++; if (bus_addr_q.size() !== 1) begin bad++; $display("FAIL flush_wb_count got=%0d want=1", bus_addr_q.size()); end
    total++; if (bus_we_q.size() < 1 || bus_we_q[0] !== 1'b1 || bus_addr_q[0] !== 28'h14 ||
                 bus_data_q[0] !== {32'hC3, 32'hC2, 32'hDEADBEEF, 32'hC0}) begin
      bad++; $display("FAIL flush_wb_line got_n=%0d want=write@14 c3_c2_deadbeef_c0", bus_addr_q.size()); end
    @(negedge clk);
    bus_req_ready = 1'b0;
    #1;
    total++; if (flush_done !== 1'b0) begin bad++; $display("FAIL flush_done_pulse got=%b want=0", flush_done); end
    core_op(1'b0, 30'h10, 4'h0, 32'h0, LINE_A, 0, r, lat);
    total++; if (bus_addr_q.size() !== 1 || bus_we_q[0] !== 1'b0 || bus_addr_q[0] !== 28'h4 || r !== 32'hA0) begin
      bad++; $display("FAIL post_flush_miss got_n=%0d data=%h want=read@4/000000a0", bus_addr_q.size(), r); end
  endtask

  task automatic test_stall();
    logic [31:0] r; int lat;
    core_op(1'b0, 30'h73, 4'h0, 32'h0, LINE_D, 20, r, lat);
    total++; if (stall_cycles !== 20) begin bad++; $display("FAIL stall_cycles got=%0d want=20", stall_cycles); end
    total++; if (unstable !== 0) begin bad++; $display("FAIL stall_stable got=%0d changes want=0", unstable); end
    total++; if (bus_addr_q.size() !== 1 || bus_addr_q[0] !== 28'h1C || r !== 32'hD3) begin
      bad++; $display("FAIL stall_result got_n=%0d data=%h want=read@1c/000000d3", bus_addr_q.size(), r); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; int lat; int n; logic seen;
    @(negedge clk);
    core_req_valid = 1'b1; core_req_we = 1'b0; core_req_addr = 30'h90;
    #1;
    n = 0;
    while (!core_req_ready && n < 50) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    core_req_valid = 1'b0; bus_req_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus_resp_ready) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL mid_reach_fill_wait got=%b want=1", seen); end
    rst = 1'b1; bus_req_ready = 1'b0; bus_resp_valid = 1'b1; bus_resp_data = LINE_A;
    #1;
    total++; if (core_resp_valid !== 1'b0) begin bad++; $display("FAIL mid_resp_in_reset got=%b want=0", core_resp_valid); end
    @(negedge clk);
    #1;
    total++; if (bus_req_valid !== 1'b0 || bus_resp_ready !== 1'b0 || core_resp_valid !== 1'b0 || core_req_ready !== 1'b0) begin
      bad++; $display("FAIL mid_outputs got=%b%b%b%b want=0000", bus_req_valid, bus_resp_ready, core_resp_valid, core_req_ready); end
    @(negedge clk);
    rst = 1'b0; bus_resp_valid = 1'b0;
    #1;
    n = 0;
    while (!core_req_ready && n < 30) begin n++; @(negedge clk); #1; end
    total++; if (n !== 8) begin bad++; $display("FAIL mid_init_cycles got=%0d want=8", n); end
    core_op(1'b0, 30'h10, 4'h0, 32'h0, LINE_B, 0, r, lat);
    total++; if (bus_addr_q.size() !== 1 || bus_addr_q[0] !== 28'h4 || r !== 32'hB0) begin
      bad++; $display("FAIL mid_invalidated got_n=%0d data=%h want=read@4/000000b0", bus_addr_q.size(), r); end
  endtask

  initial begin
    rst = 1'b1;
    core_req_valid = 1'b0; core_req_we = 1'b0; core_req_addr = '0; core_req_mask = '0; core_req_data = '0;
    flush_req = 1'b0; bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_data = '0;
    test_reset();
    test_cold_load();
    test_store_hit();
    test_evict();
    test_flush();
    test_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
